// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller:
// FSM state encodings and the slice width of the shared adder.
package adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/fourBitFullAdder.sv
// Purely combinational 4-bit ripple-carry adder; the controller
// reuses this one instance for every nibble of a wide addition.
module fourBitFullAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide unsigned adder built by stepping one shared 4-bit adder across
// the operands, LSB nibble first, one nibble per clock.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        zero
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] add_a, add_b, add_sum;
  logic                add_cout;

  // Nibble select mux: slice the frozen operands, then pick slice idx.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = op_a_q[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = op_b_q[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign add_a = a_nib[idx_q];
  assign add_b = b_nib[idx_q];

  fourBitFullAdder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = add_sum;
        carry_d = add_cout;
        // idx is held on the final step so it never wraps mid-operation.
        if (idx_q == IDX_LAST) begin
          cout_d  = add_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign zero = (sum_q == '0);

endmodule
